addsub_result_buffer: RTL and testbench

Downstream stage of the 4-bit adder/subtractor. Captures each add/sub result with its operands and derives a full ALU flag set (C, Z, N, V). Queues entries in a small synchronous FIFO and releases them over a valid/ready handshake to the consumer (register file or display stage). Decouples the combinational datapath from a consumer that may stall.

---
 rtl/addsub_result_buffer.sv | 156 +++++++++++++++
 tb/tb_addsub_result_buffer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_result_buffer.sv
// Result buffer behind the 4-bit adder/subtractor: captures result + C/Z/N/V flags into a
// show-ahead FIFO drained over valid/ready. Optional saturating drop counter: ADDSUB_DROP_CNT_EN.
module addsub_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_en,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_op,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             drop_flag,
`ifdef ADDSUB_DROP_CNT_EN
  output logic [7:0]       drop_cnt,
`endif
  input  logic             drop_clr
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             op;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
  } entry_t;

  // Signed overflow: add overflows when like-signed operands give an unlike-signed result;
  // subtract overflows when operand signs differ and the result sign differs from a.
  function automatic entry_t make_entry(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                        input logic [WIDTH-1:0] r, input logic op,
                                        input logic cout);
    entry_t e;
    e.result = r;
    e.op     = op;
    e.c      = cout;
    e.z      = (r == {WIDTH{1'b0}});
    e.n      = r[WIDTH-1];
    if (op) begin
      e.v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else begin
      e.v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    return e;
  endfunction

  entry_t        mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          drop_flag_r;
  logic          full_s;
  logic          empty_s;
  logic          wr_fire_s;
  logic          rd_fire_s;
  logic          drop_s;
  entry_t        out_entry_s;

  assign full_s    = (count_r == DEPTH_C);
  assign empty_s   = (count_r == {(AW+1){1'b0}});
  assign wr_fire_s = in_valid && !full_s;
  assign rd_fire_s = out_ready && !empty_s;
  assign drop_s    = in_valid && full_s;

  // Pointer and occupancy state; wrap is implicit in the AW-bit pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (wr_fire_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (rd_fire_s) rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({wr_fire_s, rd_fire_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) mem_r[wr_ptr_r] <= make_entry(in_a, in_b, in_result, in_en, in_cout);
  end

  // Sticky drop indication; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_flag_r <= 1'b0;
    end else if (drop_s) begin
      drop_flag_r <= 1'b1;
    end else if (drop_clr) begin
      drop_flag_r <= 1'b0;
    end
  end

`ifdef ADDSUB_DROP_CNT_EN
  logic [7:0] drop_cnt_r;

  // Saturating drop counter; clear-with-drop restarts at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_clr) begin
      drop_cnt_r <= drop_s ? 8'd1 : 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'd255)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

  // Show-ahead head; outputs read as zero whenever the buffer is empty.
  always_comb begin
    out_entry_s = '0;
    if (empty_s) begin
      out_entry_s = '0;
    end else begin
      out_entry_s = mem_r[rd_ptr_r];
    end
  end

  assign in_ready   = !full_s;
  assign out_valid  = !empty_s;
  assign out_result = out_entry_s.result;
  assign out_op     = out_entry_s.op;
  assign out_c      = out_entry_s.c;
  assign out_z      = out_entry_s.z;
  assign out_n      = out_entry_s.n;
  assign out_v      = out_entry_s.v;
  assign count      = count_r;
  assign full       = full_s;
  assign empty      = empty_s;
  assign drop_flag  = drop_flag_r;

endmodule

// File: tb/tb_addsub_result_buffer.sv
// Self-checking bench for addsub_result_buffer: directed steps plus random traffic, scored
// against a queue model that derives flags from signed integer arithmetic.
module tb_addsub_result_buffer;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_en = 1'b0, in_cout = 1'b0, out_ready = 1'b0, drop_clr = 1'b0;
  logic [WIDTH-1:0] in_a = 4'd0, in_b = 4'd0, in_result = 4'd0;
  logic in_ready, out_valid, out_op, out_c, out_z, out_n, out_v, full, empty, drop_flag;
  logic [WIDTH-1:0] out_result;
  logic [2:0] count;
`ifdef ADDSUB_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  addsub_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_en(in_en), .in_result(in_result), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
    .out_c(out_c), .out_z(out_z), .out_n(out_n), .out_v(out_v), .count(count),
    .full(full), .empty(empty), .drop_flag(drop_flag),
`ifdef ADDSUB_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  bit m_flag = 1'b0;
  int m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected entry {result, op, C, Z, N, V} from signed integer arithmetic.
  function automatic logic [8:0] model_entry(input logic [3:0] a, input logic [3:0] b,
                                             input bit sub, input bit cout);
    int sa, sb, s;
    logic [31:0] sv;
    logic [3:0] r;
    bit v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s = sub ? sa - sb : sa + sb;
    sv = s;
    r = sv[3:0];
    v = (s > 7) || (s < -8);
    return {r, sub, cout, (r == 4'd0), r[3], v};
  endfunction

  task automatic check_all();
    logic [8:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 9'd0;
    check("out_valid", out_valid, exp_q.size() > 0);
    check("count", count, exp_q.size());
    check("full", full, exp_q.size() == DEPTH);
    check("empty", empty, exp_q.size() == 0);
    check("in_ready", in_ready, exp_q.size() != DEPTH);
    check("drop_flag", drop_flag, m_flag);
    check("head", {out_result, out_op, out_c, out_z, out_n, out_v}, head);
`ifdef ADDSUB_DROP_CNT_EN
    check("drop_cnt", drop_cnt, m_cnt);
`endif
  endtask

  // One clock: drive at negedge, check, update model, advance to next negedge.
  task automatic cycle(input bit iv, input logic [3:0] a, input logic [3:0] b, input bit sub,
                       input bit rdy, input bit clr);
    logic [4:0] raw;
    bit cout, fullm, drop;
    raw = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    cout = sub ? (a < b) : (int'(a) + int'(b) > 15);
    in_valid = iv; in_a = a; in_b = b; in_en = sub; in_result = raw[3:0]; in_cout = cout;
    out_ready = rdy; drop_clr = clr;
    #1;
    check_all();
    fullm = exp_q.size() == DEPTH;
    drop = iv && fullm;
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (iv && !fullm) exp_q.push_back(model_entry(a, b, sub, cout));
    if (drop) m_flag = 1'b1;
    else if (clr) m_flag = 1'b0;
    if (clr) m_cnt = drop ? 1 : 0;
    else if (drop && m_cnt < 255) m_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rnd_write(input bit rdy);
    cycle(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), rdy, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);

    // Worked vectors from the datasheet, held until all four are queued.
    cycle(1'b1, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b0);
    #1;
    check("tp1_result", out_result, 32'h8);
    check("tp1_czn_v", {out_c, out_z, out_n, out_v}, 32'b0011);
    check("tp1_count", count, 32'd1);
    cycle(1'b1, 4'b0110, 4'b1111, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'b1101, 4'b0110, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'b0110, 4'b1100, 1'b1, 1'b0, 1'b0);
    #1;
    check("fill_full", full, 32'd1);
    check("fill_in_ready", in_ready, 32'd0);
    cycle(1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0);
    #1;
    check("drop_set", drop_flag, 32'd1);
    repeat (4) cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    #1;
    check("drain_empty", empty, 32'd1);
    check("drain_zero_out", {out_result, out_op, out_c, out_z, out_n, out_v}, 32'd0);
    cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);  // read while empty: nothing moves
    cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Steady streaming at occupancy two.
    rnd_write(1'b0);
    rnd_write(1'b0);
    for (int i = 0; i < 10; i++) begin
      rnd_write(1'b1);
      #1;
      check("stream_count", count, 32'd2);
    end

    // Fill, then drop coinciding with clear.
    rnd_write(1'b0);
    rnd_write(1'b0);
    cycle(1'b1, 4'd5, 4'd2, 1'b0, 1'b0, 1'b1);
    #1;
    check("drop_vs_clr", drop_flag, 32'd1);

    // Async reset with three entries queued.
    cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_count", count, 32'd0);
    check("rst_drop_flag", drop_flag, 32'd0);
    exp_q.delete();
    m_flag = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 4'b1001, 4'b0010, 1'b1, 1'b0, 1'b0);
    #1;
    check("post_rst_head", out_result, 32'h7);
    check("post_rst_v", out_v, 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));

`ifdef ADDSUB_DROP_CNT_EN
    cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() < DEPTH) rnd_write(1'b0);
    for (int i = 0; i < 300; i++) rnd_write(1'b0);
    #1;
    check("cnt_saturate", drop_cnt, 32'd255);
    cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check("cnt_clear", drop_cnt, 32'd0);
`endif
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
